uart_baud_tick_gen: RTL and testbench

Programmable baud-tick generator for the UART. Produces single-cycle enable pulses instead of toggled clocks, so all UART logic runs on `clk`. There is a runtime-loadable divisor with a glitch-free update handshake, and independent rx/tx phase counters. The rx phase can be realigned on a start-bit edge. It feeds the rx sampler (oversample and mid-bit ticks) and the tx shifter (bit tick).

---
 rtl/uart_baud_pkg.sv | 20 ++
 rtl/baud_tick_divider.sv | 88 ++++++++
 rtl/uart_baud_tick_gen.sv | 148 ++++++++++++++
 tb/tb_uart_baud_tick_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_baud_pkg.sv
// Shared types and constants for the UART baud tick generator.
package uart_baud_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int unsigned MIN_DIV = 2;

    function automatic longint unsigned default_div(
        input longint unsigned clk_freq,
        input longint unsigned baud,
        input longint unsigned os
    );
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/baud_tick_divider.sv
// One tick path: base counter, oversample counter, optional fraction.
// Fractional stretching is compiled in with BAUD_FRAC_EN.
module baud_tick_divider
    import uart_baud_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16,
    parameter int FRAC_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_i,
    input  logic                 sync_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [FRAC_BITS-1:0] frac_i,
    output logic                 wrap_now_o,
    output logic                 tick_o,
    output logic                 mid_o,
    output logic                 wrap_o
);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_WIDTH-1:0] base_q, base_d;
    logic [OS_W-1:0]      os_q, os_d;
    logic                 tick_q, mid_q, wrap_q;
    logic [DIV_WIDTH:0]   limit;
    logic                 base_wrap, os_last;

`ifdef BAUD_FRAC_EN
    logic [FRAC_BITS-1:0] acc_q, acc_d;
    logic [FRAC_BITS:0]   acc_sum;

    // A carry out of the accumulator stretches this period by one cycle.
    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_i};
    assign limit = {1'b0, div_i} - (DIV_WIDTH+1)'(1)
                 + (DIV_WIDTH+1)'(acc_sum[FRAC_BITS]);
    assign acc_d = base_wrap ? acc_sum[FRAC_BITS-1:0] : acc_q;

    always_ff @(posedge clk) begin
        if (!reset || !en_i || sync_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic unused_frac;

    assign unused_frac = ^frac_i;
    assign limit = {1'b0, div_i} - (DIV_WIDTH+1)'(1);
`endif

    assign base_wrap = en_i & ~sync_i & ({1'b0, base_q} >= limit);
    assign os_last = (os_q == OS_LAST);
    assign wrap_now_o = base_wrap & os_last;

    always_comb begin
        base_d = base_q + DIV_WIDTH'(1);
        os_d = os_q;
        if (base_wrap) begin
            base_d = '0;
            os_d = os_last ? '0 : os_q + OS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || !en_i || sync_i) begin
            base_q <= '0;
            os_q <= '0;
            tick_q <= 1'b0;
            mid_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            base_q <= base_d;
            os_q <= os_d;
            tick_q <= base_wrap;
            mid_q <= base_wrap & (os_q == OS_MID);
            wrap_q <= wrap_now_o;
        end
    end

    assign tick_o = tick_q;
    assign mid_o = mid_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/uart_baud_tick_gen.sv
// Baud tick generator: FSM, shadow divisor and load handshake.
// Define BAUD_FRAC_EN to enable the fractional divisor.
module uart_baud_tick_gen
    import uart_baud_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int DEFAULT_BAUD = 115200,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_WIDTH    = 16,
    parameter int FRAC_BITS    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic [FRAC_BITS-1:0] divFrac,
    input  logic                 divLoad,
    output logic                 divAck,
    input  logic                 rxSync,
    output logic                 rxTick,
    output logic                 rxMidTick,
    output logic                 txTick,
    output logic                 running
);
    localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(
        default_div(64'(CLK_FREQ), 64'(DEFAULT_BAUD), 64'(OVERSAMPLE)));
    localparam logic [DIV_WIDTH-1:0] MIN_DIV_W = DIV_WIDTH'(MIN_DIV);

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
    logic [DIV_WIDTH-1:0] div_clamp;
    logic [FRAC_BITS-1:0] frac_act;
    logic                 ack_q, apply, run_en, tx_wrap_now;
    logic                 unused_rx_wrap_now, unused_rx_wrap;
    logic                 unused_tx_tick, unused_tx_mid;

    assign div_clamp = (divisor < MIN_DIV_W) ? MIN_DIV_W : divisor;
    assign shadow_d = divLoad ? div_clamp : shadow_q;
    assign div_d = apply ? shadow_d : div_q;
    assign run_en = enable & (state_q != IDLE);

`ifdef BAUD_FRAC_EN
    logic [FRAC_BITS-1:0] frac_q, frac_d;
    logic [FRAC_BITS-1:0] fshadow_q, fshadow_d;

    assign fshadow_d = divLoad ? divFrac : fshadow_q;
    assign frac_d = apply ? fshadow_d : frac_q;
    assign frac_act = frac_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            frac_q <= '0;
            fshadow_q <= '0;
        end else begin
            frac_q <= frac_d;
            fshadow_q <= fshadow_d;
        end
    end
`else
    logic unused_div_frac;

    assign unused_div_frac = ^divFrac;
    assign frac_act = '0;
`endif

    // A load seen in RUN waits in PEND for the next tx bit boundary.
    always_comb begin
        state_d = state_q;
        apply = 1'b0;
        unique case (state_q)
            IDLE: begin
                apply = divLoad;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    apply = divLoad;
                end else if (divLoad) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!enable) begin
                    state_d = IDLE;
                    apply = 1'b1;
                end else if (tx_wrap_now) begin
                    state_d = RUN;
                    apply = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q <= DEFAULT_DIV;
            shadow_q <= DEFAULT_DIV;
            ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q <= div_d;
            shadow_q <= shadow_d;
            ack_q <= apply;
        end
    end

    baud_tick_divider #(
        .DIV_WIDTH (DIV_WIDTH),
        .OVERSAMPLE(OVERSAMPLE),
        .FRAC_BITS (FRAC_BITS)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .en_i      (run_en),
        .sync_i    (rxSync),
        .div_i     (div_q),
        .frac_i    (frac_act),
        .wrap_now_o(unused_rx_wrap_now),
        .tick_o    (rxTick),
        .mid_o     (rxMidTick),
        .wrap_o    (unused_rx_wrap)
    );

    baud_tick_divider #(
        .DIV_WIDTH (DIV_WIDTH),
        .OVERSAMPLE(OVERSAMPLE),
        .FRAC_BITS (FRAC_BITS)
    ) u_tx (
        .clk       (clk),
        .reset     (reset),
        .en_i      (run_en),
        .sync_i    (1'b0),
        .div_i     (div_q),
        .frac_i    (frac_act),
        .wrap_now_o(tx_wrap_now),
        .tick_o    (unused_tx_tick),
        .mid_o     (unused_tx_mid),
        .wrap_o    (txTick)
    );

    assign divAck = ack_q;
    assign running = (state_q != IDLE);

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Bench for uart_baud_tick_gen against an event-time reference model.
module tb_uart_baud_tick_gen;
    localparam int OS  = 16;
    localparam int DW  = 16;
    localparam int FB  = 4;
    localparam int DEF = 16;

    logic          clk = 1'b0;
    logic          reset, enable, divLoad, rxSync;
    logic [DW-1:0] divisor;
    logic [FB-1:0] divFrac;
    logic          divAck, rxTick, rxMidTick, txTick, running;

    int vecs = 0;
    int errs = 0;

    // Model: tick times are scheduled as absolute cycle numbers.
    bit mRun, mPend;
    int P, S, t;
    int rxLast, rxNext, rxK, txNext;
    bit eRx, eMid, eTx, eAck;

    always #5 clk = ~clk;

    uart_baud_tick_gen #(
        .CLK_FREQ    (32_000_000),
        .DEFAULT_BAUD(125000),
        .OVERSAMPLE  (OS),
        .DIV_WIDTH   (DW),
        .FRAC_BITS   (FB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .divisor  (divisor),
        .divFrac  (divFrac),
        .divLoad  (divLoad),
        .divAck   (divAck),
        .rxSync   (rxSync),
        .rxTick   (rxTick),
        .rxMidTick(rxMidTick),
        .txTick   (txTick),
        .running  (running)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, t, got, exp);
        end
    endtask

    function automatic int clampd(int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_edge(bit rst, bit en, bit ld, int dv, bit sy);
        bit txFire, rxFire, apply;
        int newP;
        t++;
        eRx = 0;
        eMid = 0;
        eTx = 0;
        eAck = 0;
        if (rst) begin
            mRun = 0;
            mPend = 0;
            P = DEF;
            S = DEF;
            return;
        end
        txFire = mRun && en && (txNext == t);
        rxFire = mRun && en && !sy && (rxNext == t);
        if (!mRun) begin
            if (ld) begin
                P = clampd(dv);
                eAck = 1;
            end
            if (en) begin
                mRun = 1;
                rxLast = t;
                rxNext = t + P;
                rxK = 0;
                txNext = t + P * OS;
            end
        end else if (!en) begin
            if (ld || mPend) begin
                P = ld ? clampd(dv) : S;
                eAck = 1;
            end
            mRun = 0;
            mPend = 0;
        end else begin
            apply = 0;
            newP = P;
            if (mPend && txFire) begin
                apply = 1;
                newP = ld ? clampd(dv) : S;
                mPend = 0;
                eAck = 1;
            end else if (ld) begin
                S = clampd(dv);
                mPend = 1;
            end
            eTx = txFire;
            eRx = rxFire;
            eMid = rxFire && ((rxK % OS) == OS / 2 - 1);
            if (sy) begin
                rxLast = t;
                rxNext = t + newP;
                rxK = 0;
            end else if (rxFire) begin
                rxLast = t;
                rxNext = t + newP;
                rxK++;
            end else if (apply) begin
                rxNext = (t + 1 > rxLast + newP) ? t + 1 : rxLast + newP;
            end
            if (txFire) txNext = t + newP * OS;
            P = newP;
        end
    endtask

    task automatic cyc(bit rst, bit en, bit ld, int dv, bit sy);
        reset = ~rst;
        enable = en;
        divLoad = ld;
        divisor = DW'(dv);
        rxSync = sy;
        @(posedge clk);
        model_edge(rst, en, ld, dv, sy);
        #1;
        check("rxTick", 32'(rxTick), 32'(eRx));
        check("rxMidTick", 32'(rxMidTick), 32'(eMid));
        check("txTick", 32'(txTick), 32'(eTx));
        check("divAck", 32'(divAck), 32'(eAck));
        check("running", 32'(running), 32'(mRun));
    endtask

    initial begin
        bit en_r;
        reset = 1'b0;
        enable = 1'b0;
        divLoad = 1'b0;
        divisor = '0;
        divFrac = '0;
        rxSync = 1'b0;
        t = 0;

`ifdef BAUD_FRAC_EN
        begin
            int n, ticks, first;
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b1;
            divisor = DW'(4);
            divFrac = FB'(8);
            divLoad = 1'b1;
            @(posedge clk);
            #1;
            divLoad = 1'b0;
            divFrac = '0;
            enable = 1'b1;
            @(posedge clk);
            #1;
            n = 0;
            ticks = 0;
            first = 0;
            while (ticks < 16 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
                if (rxTick) begin
                    ticks++;
                    if (ticks == 1) first = n;
                end
            end
            check("frac_first", 32'(first), 32'(4));
            check("frac_16ticks", 32'(n), 32'(72));
            enable = 1'b0;
        end
`endif

        repeat (3) cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);

        repeat (600) cyc(0, 1, 0, 0, 0);

        repeat (37) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 4, 0);
        repeat (400) cyc(0, 1, 0, 0, 0);

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        repeat (100) cyc(0, 1, 0, 0, 0);

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 4, 0);
        repeat (50) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        repeat (150) cyc(0, 1, 0, 0, 0);

        cyc(0, 1, 1, 6, 0);
        repeat (20) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        repeat (100) cyc(0, 1, 0, 0, 0);

        en_r = 1;
        for (int i = 0; i < 8000; i++) begin
            bit r, l, s;
            int d;
            if ($urandom_range(0, 299) == 0) en_r = ~en_r;
            r = ($urandom_range(0, 999) == 0);
            l = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 39) == 0);
            d = $urandom_range(0, 7);
            cyc(r, en_r, l, d, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
